// File: rtl/dmux_merge.sv
// Four-to-one valid/ready merge with a single registered output slot and a source tag.
// Define DMUX_MERGE_FIXED_PRIO_EN for fixed priority (channel 0 highest); default is round-robin.
module dmux_merge #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din0,
   input  logic [WIDTH-1:0] din1,
   input  logic [WIDTH-1:0] din2,
   input  logic [WIDTH-1:0] din3,
   input  logic [3:0]       din_valid,
   output logic [3:0]       din_ready,
   output logic [WIDTH-1:0] dout,
   output logic [1:0]       dout_sel,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [CNT_W-1:0] beat_cnt
);

   logic [WIDTH-1:0] dout_q, dout_d;
   logic [1:0]       sel_q, sel_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [1:0]       grant_idx;
   logic             grant_any;
   logic             slot_free;
   logic             accept;
   logic [WIDTH-1:0] win_data;

`ifdef DMUX_MERGE_FIXED_PRIO_EN
   // Scan from lowest priority upward so the lowest-numbered requester is written last and wins.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
      grant_any = 1'b0;
      grant_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (din_valid[i]) begin
            grant_any = 1'b1;
            grant_idx = 2'(i);
         end
      end
   end
`else
   logic [1:0] last_q;
   logic [1:0] cand;

   // Search order is last+1 .. last+4 (== last); scanning it backwards lets the nearest requester win.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = last_q;
      cand      = last_q;
      for (int k = 4; k >= 1; k--) begin
         cand = last_q + 2'(k);
         if (din_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 2'b11;
      end else if (accept) begin
         last_q <= grant_idx;
      end
   end
`endif

   // rst_n gates the grant so no source sees ready while the block is held in reset.
   assign slot_free = !valid_q || dout_ready;
   assign accept    = rst_n && slot_free && grant_any;
   assign din_ready = accept ? (4'b0001 << grant_idx) : 4'b0000;

   always_comb begin
      unique case (grant_idx)
         2'd0:    win_data = din0;
         2'd1:    win_data = din1;
         2'd2:    win_data = din2;
         default: win_data = din3;
      endcase
   end

   always_comb begin
      dout_d  = dout_q;
      sel_d   = sel_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (accept) begin
         dout_d  = win_data;
         sel_d   = grant_idx;
         valid_d = 1'b1;
      end else if (dout_ready) begin
         valid_d = 1'b0;
      end
      if (valid_q && dout_ready) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // The output data register is reset too: downstream expects dout=0 straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q  <= '0;
         sel_q   <= 2'b00;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
         dout_q  <= dout_d;
         sel_q   <= sel_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout       = dout_q;
   assign dout_sel   = sel_q;
   assign dout_valid = valid_q;
   assign beat_cnt   = cnt_q;

endmodule

// File: tb/tb_dmux_merge.sv
// Scoreboard bench for dmux_merge: a reference arbiter predicts grants and the output word order.
module tb_dmux_merge;
   localparam int WIDTH = 32;
   localparam int CNT_W = 4;
   localparam int DEPTH = 1024;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic [1:0]       sel;
   } beat_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] din_d [4];
   logic [3:0]       vld;
   logic [3:0]       din_ready;
   logic [WIDTH-1:0] dout;
   logic [1:0]       dout_sel;
   logic             dout_valid;
   logic             dout_ready;
   logic [CNT_W-1:0] beat_cnt;

   always #5 clk = ~clk;

   dmux_merge #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din0      (din_d[0]),
      .din1      (din_d[1]),
      .din2      (din_d[2]),
      .din3      (din_d[3]),
      .din_valid (vld),
      .din_ready (din_ready),
      .dout      (dout),
      .dout_sel  (dout_sel),
      .dout_valid(dout_valid),
      .dout_ready(dout_ready),
      .beat_cnt  (beat_cnt)
   );

   int checks = 0;
   int errors = 0;

   // Per-channel source word lists and the expected output order.
   logic [WIDTH-1:0] src_mem [4][DEPTH];
   int               head [4];
   int               tail [4];
   beat_t            exp_q [$];

   // Reference model state: most recently granted channel and whether the slot holds a word.
   int               m_last;
   bit               m_full;
   logic [CNT_W-1:0] m_beats;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_word(input int ch, input logic [WIDTH-1:0] data);
      src_mem[ch][tail[ch]] = data;
      tail[ch]++;
   endtask

   function automatic int pending();
      int n = 0;
      for (int c = 0; c < 4; c++) n += tail[c] - head[c];
      return n;
   endfunction

   // One clock: starts and ends 1 time unit after a rising edge.
   task automatic step(input bit rdy, input int valid_pct);
      int         g;
      int         c;
      bit         free;
      logic [3:0] exp_rdy;
      beat_t      b;
      for (int ch = 0; ch < 4; ch++) begin
         if (!vld[ch] && head[ch] < tail[ch] && $urandom_range(0, 99) < valid_pct) begin
            vld[ch]   = 1'b1;
            din_d[ch] = src_mem[ch][head[ch]];
         end
      end
      dout_ready = rdy;
      #1;
      free = !m_full || rdy;
      g    = -1;
`ifdef DMUX_MERGE_FIXED_PRIO_EN
      for (int k = 0; k < 4; k++) if (g < 0 && vld[k]) g = k;
`else
      for (int k = 1; k <= 4; k++) begin
         c = (m_last + k) % 4;
         if (g < 0 && vld[c]) g = c;
      end
`endif
      if (!free) g = -1;
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
      check("din_ready", 64'(din_ready), 64'(exp_rdy));
      if (g >= 0) begin
         b.data = din_d[g];
         b.sel  = 2'(g);
         exp_q.push_back(b);
         head[g]++;
         m_last = g;
         m_full = 1'b1;
      end else if (rdy) begin
         m_full = 1'b0;
      end
      @(posedge clk);
      #1;
      if (g >= 0) begin
         vld[g]   = 1'b0;
         din_d[g] = $urandom;
      end
   endtask

   task automatic drain(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (pending() == 0 && vld == 4'b0000 && exp_q.size() == 0) break;
         step(1'b1, 100);
      end
      check("drain_left", 64'(pending() + exp_q.size()), 64'd0);
   endtask

   task automatic clear_model();
      vld = 4'b0000;
      for (int c = 0; c < 4; c++) begin
         head[c] = 0;
         tail[c] = 0;
      end
      exp_q.delete();
      m_last = 3;
      m_full = 1'b0;
   endtask

   // Monitor: compares the presented word with the queue head and pops on each output transfer.
   always @(negedge clk) begin
      if (!rst_n) begin
         m_beats = '0;
      end else begin
         check("beat_cnt", 64'(beat_cnt), 64'(m_beats));
         check("valid_lost", 64'(!dout_valid && exp_q.size() > 1), 64'd0);
         if (exp_q.size() == 0) begin
            check("spurious_valid", 64'(dout_valid), 64'd0);
         end else if (dout_valid) begin
            check("dout", 64'(dout), 64'(exp_q[0].data));
            check("dout_sel", 64'(dout_sel), 64'(exp_q[0].sel));
            if (dout_ready) begin
               void'(exp_q.pop_front());
               m_beats = m_beats + 1'b1;
            end
         end
      end
   end

   initial begin
      rst_n      = 1'b0;
      dout_ready = 1'b0;
      for (int c = 0; c < 4; c++) din_d[c] = '0;
      clear_model();

      // Reset state, with every source requesting.
      #2;
      vld = 4'hF;
      for (int c = 0; c < 4; c++) din_d[c] = 32'hA0 + c;
      dout_ready = 1'b1;
      #1;
      check("rst_din_ready", 64'(din_ready), 64'd0);
      check("rst_dout_valid", 64'(dout_valid), 64'd0);
      check("rst_dout", 64'(dout), 64'd0);
      check("rst_dout_sel", 64'(dout_sel), 64'd0);
      check("rst_beat_cnt", 64'(beat_cnt), 64'd0);
      vld = 4'h0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // All four channels with A0..A3, sink always ready.
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 4; c++) push_word(c, 32'hA0 + c);
      drain(40);

      // Only channel 2 with all-ones data.
      push_word(2, 32'hFFFF_FFFF);
      drain(10);

      // Backpressure: slot filled from channel 1, sink stalled five clocks with all channels valid.
      push_word(1, 32'hB1);
      step(1'b0, 100);
      for (int c = 0; c < 4; c++) push_word(c, 32'hC0 + c);
      repeat (5) step(1'b0, 100);
      drain(20);

      // Channels 0 and 3 continuously valid.
      for (int r = 0; r < 6; r++) begin
         push_word(0, 32'hD000 + r);
         push_word(3, 32'hD300 + r);
      end
      drain(30);

      // Random traffic with random sink stalls.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 9) < 3) push_word($urandom_range(0, 3), $urandom);
         step($urandom_range(0, 3) != 0, 60);
      end
      drain(200);

      // Reset while the slot is full.
      for (int c = 0; c < 4; c++) push_word(c, 32'hE0 + c);
      step(1'b0, 100);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_dout_valid", 64'(dout_valid), 64'd0);
      check("midrst_dout", 64'(dout), 64'd0);
      check("midrst_beat_cnt", 64'(beat_cnt), 64'd0);
      check("midrst_din_ready", 64'(din_ready), 64'd0);
      clear_model();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) push_word(c, 32'hF0 + c);
      drain(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Time bound in case the bench itself stalls.
   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
